// File: rtl/ahb_ral_ahb_master.sv
// AHB-Lite initiator issuing single 32-bit transfers from a valid/ready command port,
// returning read data and status (error / timeout) on a valid/ready response port.
module ahb_ral_ahb_master #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              hclk,
   input  logic              hresetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_error,
   output logic              rsp_timeout,
   output logic              hsel,
   output logic [ADDR_W-1:0] haddr,
   output logic [1:0]        htrans,
   output logic              hwrite,
   output logic [2:0]        hsize,
   output logic [2:0]        hburst,
   output logic [DATA_W-1:0] hwdata,
   input  logic [DATA_W-1:0] hrdata,
   input  logic              hready,
   input  logic              hresp
);

   localparam int         CNT_W         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

   state_e              state_q, state_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_error_q, rsp_error_d;
   logic                rsp_timeout_q, rsp_timeout_d;
   logic                hsel_q, hsel_d;
   logic [ADDR_W-1:0]   haddr_q, haddr_d;
   logic [1:0]          htrans_q, htrans_d;
   logic                hwrite_q, hwrite_d;
   logic [DATA_W-1:0]   hwdata_q, hwdata_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    cnt_sat_inc;

   logic cmd_fire;
   logic aligned;
   logic bus_busy;
   logic timeout_hit;

   assign cmd_fire    = (state_q == IDLE) && cmd_valid && cmd_ready_q;
   assign aligned     = (cmd_addr[1:0] == 2'b00);
   assign bus_busy    = (state_q == ADDR) || (state_q == DATA);
   assign cnt_sat_inc = (int'(cnt_q) >= TIMEOUT) ? cnt_q : cnt_q + CNT_W'(1);
   // Fires on the edge that would count the TIMEOUT-th consecutive stalled cycle
   assign timeout_hit = (TIMEOUT > 0) && bus_busy && !hready && (int'(cnt_q) + 1 >= TIMEOUT);

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q       <= IDLE;
         cmd_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_error_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
         hsel_q        <= 1'b0;
         haddr_q       <= '0;
         htrans_q      <= HTRANS_IDLE;
         hwrite_q      <= 1'b0;
         hwdata_q      <= '0;
         wdata_q       <= '0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         cmd_ready_q   <= cmd_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_error_q   <= rsp_error_d;
         rsp_timeout_q <= rsp_timeout_d;
         hsel_q        <= hsel_d;
         haddr_q       <= haddr_d;
         htrans_q      <= htrans_d;
         hwrite_q      <= hwrite_d;
         hwdata_q      <= hwdata_d;
         wdata_q       <= wdata_d;
         cnt_q         <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (cmd_fire) state_d = aligned ? ADDR : RESP;
         ADDR: begin
            if (hready)           state_d = DATA;
            else if (timeout_hit) state_d = RESP;
         end
         DATA: if (hready || timeout_hit) state_d = RESP;
         RESP: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs; cmd_ready lags IDLE entry by one cycle
   always_comb begin
      cmd_ready_d   = (state_q == IDLE) && !cmd_fire;
      rsp_valid_d   = (state_d == RESP);
      rsp_rdata_d   = rsp_rdata_q;
      rsp_error_d   = rsp_error_q;
      rsp_timeout_d = rsp_timeout_q;
      hsel_d        = hsel_q;
      haddr_d       = haddr_q;
      htrans_d      = htrans_q;
      hwrite_d      = hwrite_q;
      hwdata_d      = hwdata_q;
      wdata_d       = wdata_q;
      cnt_d         = cnt_q;
      case (state_q)
         IDLE: begin
            if (cmd_fire && aligned) begin
               wdata_d  = cmd_wdata;
               hsel_d   = 1'b1;
               htrans_d = HTRANS_NONSEQ;
               haddr_d  = cmd_addr;
               hwrite_d = cmd_write;
               cnt_d    = '0;
            end else if (cmd_fire) begin
               rsp_error_d   = 1'b1;
               rsp_timeout_d = 1'b0;
               rsp_rdata_d   = '0;
            end
         end
         ADDR, DATA: begin
            cnt_d = hready ? '0 : cnt_sat_inc;
            if (timeout_hit) begin
               hsel_d        = 1'b0;
               htrans_d      = HTRANS_IDLE;
               rsp_rdata_d   = '0;
               rsp_error_d   = 1'b1;
               rsp_timeout_d = 1'b1;
            end else if (hready && state_q == ADDR) begin
               htrans_d = HTRANS_IDLE;
               hwdata_d = hwrite_q ? wdata_q : '0;
            end else if (hready) begin
               hsel_d        = 1'b0;
               rsp_rdata_d   = (hwrite_q || hresp) ? '0 : hrdata;
               rsp_error_d   = hresp;
               rsp_timeout_d = 1'b0;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_error_d   = 1'b0;
               rsp_timeout_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign cmd_ready   = cmd_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_error   = rsp_error_q;
   assign rsp_timeout = rsp_timeout_q;
   assign hsel        = hsel_q;
   assign haddr       = haddr_q;
   assign htrans      = htrans_q;
   assign hwrite      = hwrite_q;
   assign hwdata      = hwdata_q;
   assign hsize       = 3'b010;
   assign hburst      = 3'b000;

endmodule

// File: tb/tb_ahb_ral_ahb_master.sv
// Scoreboard bench for ahb_ral_ahb_master: a behavioural AHB slave answers the bus,
// a reference model predicts every response, and a monitor compares as responses appear.
module tb_ahb_ral_ahb_master;

   localparam int TMO = 4;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_error, rsp_timeout;
   logic        hsel, hwrite, hready, hresp;
   logic [31:0] haddr, hwdata, hrdata;
   logic [1:0]  htrans;
   logic [2:0]  hsize, hburst;

   ahb_ral_ahb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
      .hclk(hclk), .hresetn(hresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
      .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
      .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
      .hrdata(hrdata), .hready(hready), .hresp(hresp)
   );

   always #5 hclk = ~hclk;

   int cyc = 0;
   always @(posedge hclk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      int          aw;
      int          dw;
      logic        er;
   } plan_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        tmo;
      int          lat;
      int          hold;
      int          hs;
   } exp_t;

   plan_t       planQ[$];
   exp_t        expQ[$];
   logic [31:0] refMem [0:2047];
   logic [31:0] slvMem [0:2047];
   int          total = 0;
   int          bad = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic reportFail(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s: got no such event, expected it within bound", name);
   endtask

   // Expected response from the transfer rules: misalignment, then stall limits, then ERROR
   function automatic exp_t refModel(input plan_t p);
      exp_t e;
      e.rdata = 32'h0;
      e.err   = 1'b0;
      e.tmo   = 1'b0;
      e.hold  = 0;
      e.hs    = 0;
      if (p.addr[1:0] != 2'b00) begin
         e.err = 1'b1;
         e.lat = 1;
      end else if (p.aw >= TMO) begin
         e.err = 1'b1;
         e.tmo = 1'b1;
         e.lat = TMO + 1;
      end else if (p.dw + int'(p.er) >= TMO) begin
         e.err = 1'b1;
         e.tmo = 1'b1;
         e.lat = p.aw + TMO + 2;
      end else begin
         e.lat = p.aw + p.dw + int'(p.er) + 3;
         if (p.er) e.err = 1'b1;
         else if (p.wr) refMem[p.addr[12:2]] = p.wdata;
         else e.rdata = refMem[p.addr[12:2]];
      end
      return e;
   endfunction

   task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                                input int aw, input int dw, input logic er, input int hold);
      plan_t p;
      exp_t  e;
      int    n;
      n = 0;
      while (cmd_ready !== 1'b1) begin
         @(posedge hclk); #1;
         n++;
         if (n > 200) begin
            reportFail("cmd_ready wait");
            return;
         end
      end
      p.addr = addr; p.wr = wr; p.wdata = wdata; p.aw = aw; p.dw = dw; p.er = er;
      e = refModel(p);
      e.hold = hold;
      e.hs   = cyc + 1;
      if (addr[1:0] == 2'b00) planQ.push_back(p);
      expQ.push_back(e);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      @(posedge hclk); #1;
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (expQ.size() != 0 || planQ.size() != 0) begin
         @(posedge hclk); #1;
         n++;
         if (n > 500) begin
            reportFail("drain of outstanding responses");
            expQ.delete();
            planQ.delete();
         end
      end
      repeat (10) @(posedge hclk);
      #1;
   endtask

   // Behavioural AHB slave: inserts the planned wait states and ERROR responses
   initial begin : slave
      plan_t       p;
      logic        abort;
      logic [31:0] wrData;
      hready = 1'b1;
      hresp  = 1'b0;
      hrdata = 32'h0;
      forever begin
         @(posedge hclk); #1;
         if (hresetn === 1'b1 && hsel === 1'b1 && htrans === 2'b10) begin
            if (planQ.size() == 0) begin
               reportFail("unexpected bus transfer");
            end else begin
               p = planQ.pop_front();
               checkOutput("haddr", haddr, p.addr);
               checkOutput("hwrite", 32'(hwrite), 32'(p.wr));
               checkOutput("hsize/hburst", 32'({hsize, hburst}), 32'h10);
               abort = 1'b0;
               for (int k = 0; k < p.aw && !abort; k++) begin
                  hready = 1'b0;
                  @(posedge hclk); #1;
                  if (hsel !== 1'b1) abort = 1'b1;
               end
               hready = 1'b1;
               if (!abort) begin
                  @(posedge hclk); #1;
                  checkOutput("htrans in data phase", 32'(htrans), 32'h0);
                  for (int k = 0; k < p.dw && !abort; k++) begin
                     if (p.wr) checkOutput("hwdata during wait", hwdata, p.wdata);
                     hready = 1'b0;
                     hresp  = 1'b0;
                     hrdata = $urandom;
                     @(posedge hclk); #1;
                     if (hsel !== 1'b1) abort = 1'b1;
                  end
                  if (!abort && p.er) begin
                     hready = 1'b0;
                     hresp  = 1'b1;
                     @(posedge hclk); #1;
                     if (hsel !== 1'b1) abort = 1'b1;
                  end
                  if (!abort) begin
                     if (p.wr) checkOutput("hwdata at completion", hwdata, p.wdata);
                     wrData = hwdata;
                     hready = 1'b1;
                     hresp  = p.er;
                     hrdata = (p.wr || p.er) ? $urandom : slvMem[p.addr[12:2]];
                     @(posedge hclk); #1;
                     if (p.wr && !p.er) slvMem[p.addr[12:2]] = wrData;
                     checkOutput("hsel after completion", 32'(hsel), 32'h0);
                  end
               end
            end
            hready = 1'b1;
            hresp  = 1'b0;
            hrdata = $urandom;
         end
      end
   end

   // Response monitor: pops the scoreboard on each new response and handles back-pressure
   initial begin : monitor
      exp_t        e;
      logic [31:0] sr;
      logic        se, st, stable;
      rsp_ready = 1'b0;
      forever begin
         @(posedge hclk); #1;
         if (hresetn === 1'b1 && rsp_valid === 1'b1) begin
            if (expQ.size() == 0) begin
               reportFail("unexpected response");
               rsp_ready = 1'b1;
               @(posedge hclk); #1;
               rsp_ready = 1'b0;
            end else begin
               e = expQ.pop_front();
               checkOutput("rsp_rdata", rsp_rdata, e.rdata);
               checkOutput("rsp_error", 32'(rsp_error), 32'(e.err));
               checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
               checkOutput("rsp latency", 32'(cyc - e.hs + 1), 32'(e.lat));
               sr = rsp_rdata; se = rsp_error; st = rsp_timeout;
               stable = 1'b1;
               for (int k = 0; k < e.hold; k++) begin
                  @(posedge hclk); #1;
                  if (rsp_valid !== 1'b1 || rsp_rdata !== sr || rsp_error !== se || rsp_timeout !== st)
                     stable = 1'b0;
               end
               if (e.hold > 0) checkOutput("rsp held under back-pressure", 32'(stable), 32'h1);
               rsp_ready = 1'b1;
               @(posedge hclk); #1;
               rsp_ready = 1'b0;
               checkOutput("rsp_valid after accept", 32'(rsp_valid), 32'h0);
               checkOutput("rsp status after accept", 32'({rsp_error, rsp_timeout}), 32'h0);
               checkOutput("cmd_ready bubble", 32'(cmd_ready), 32'h0);
            end
         end
      end
   end

   initial begin : main
      int n;
      hresetn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = 32'h0;
      cmd_wdata = 32'h0;
      for (int i = 0; i < 2048; i++) begin
         refMem[i] = 32'h0;
         slvMem[i] = 32'h0;
      end
      repeat (3) @(posedge hclk);
      #1;
      checkOutput("reset cmd_ready", 32'(cmd_ready), 32'h0);
      checkOutput("reset rsp_valid", 32'(rsp_valid), 32'h0);
      checkOutput("reset hsel", 32'(hsel), 32'h0);
      checkOutput("reset htrans", 32'(htrans), 32'h0);
      checkOutput("reset haddr", haddr, 32'h0);
      checkOutput("reset hwdata", hwdata, 32'h0);
      @(negedge hclk);
      hresetn = 1'b1;
      @(posedge hclk); #1;
      checkOutput("cmd_ready after reset release", 32'(cmd_ready), 32'h1);

      $display("[TB] directed transfers");
      applyStimulus(32'h1000, 1'b1, 32'h0000_0007, 0, 0, 1'b0, 0);
      applyStimulus(32'h1000, 1'b0, 32'h0, 0, 0, 1'b0, 0);
      applyStimulus(32'h0040, 1'b1, 32'hDEAD_BEEF, 0, 0, 1'b0, 1);
      applyStimulus(32'h0040, 1'b0, 32'h0, 0, 3, 1'b0, 0);
      applyStimulus(32'h0044, 1'b0, 32'h0, 0, 0, 1'b1, 0);
      applyStimulus(32'h1002, 1'b0, 32'h0, 0, 0, 1'b0, 0);
      applyStimulus(32'h0044, 1'b1, 32'h1234_5678, 0, 10, 1'b0, 5);
      applyStimulus(32'h0044, 1'b0, 32'h0, 6, 0, 1'b0, 0);
      applyStimulus(32'h0044, 1'b0, 32'h0, 1, 2, 1'b1, 2);
      drain();

      $display("[TB] randomized transfers");
      for (int i = 0; i < 150; i++) begin
         logic [31:0] a;
         int          sel, aw, dw;
         sel = $urandom_range(0, 17);
         a = (sel < 16) ? 32'(sel * 4) : ((sel == 16) ? 32'h1000 : 32'h1004);
         if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
         aw = ($urandom_range(0, 11) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 2);
         dw = ($urandom_range(0, 11) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 2);
         applyStimulus(a, 1'($urandom_range(0, 1)), $urandom, aw, dw,
                       ($urandom_range(0, 5) == 0), $urandom_range(0, 2));
      end
      drain();

      $display("[TB] reset during a write data phase");
      n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
         @(posedge hclk); #1;
         n++;
      end
      planQ.push_back('{addr: 32'h48, wr: 1'b1, wdata: 32'hA5A5_5A5A, aw: 0, dw: 3, er: 1'b0});
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h48;
      cmd_wdata = 32'hA5A5_5A5A;
      @(posedge hclk); #1;
      cmd_valid = 1'b0;
      @(posedge hclk); #1;
      checkOutput("hwdata before reset", hwdata, 32'hA5A5_5A5A);
      @(negedge hclk);
      hresetn = 1'b0;
      #1;
      checkOutput("async reset hsel", 32'(hsel), 32'h0);
      checkOutput("async reset htrans", 32'(htrans), 32'h0);
      checkOutput("async reset haddr", haddr, 32'h0);
      checkOutput("async reset hwrite", 32'(hwrite), 32'h0);
      checkOutput("async reset hwdata", hwdata, 32'h0);
      checkOutput("async reset cmd_ready", 32'(cmd_ready), 32'h0);
      checkOutput("async reset rsp", 32'({rsp_valid, rsp_error, rsp_timeout}), 32'h0);
      checkOutput("async reset rsp_rdata", rsp_rdata, 32'h0);
      repeat (2) @(posedge hclk);
      @(negedge hclk);
      hresetn = 1'b1;
      planQ.delete();
      @(posedge hclk); #1;
      applyStimulus(32'h0048, 1'b0, 32'h0, 0, 0, 1'b0, 0);
      applyStimulus(32'h0048, 1'b1, 32'hCAFE_F00D, 1, 1, 1'b0, 0);
      applyStimulus(32'h0048, 1'b0, 32'h0, 0, 0, 1'b0, 0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
